// File: rtl/serial_addsub_ctrl.sv
// Bit-serial signed add/subtract sequencer: one shared full-adder cell, LSB first,
// started by a debounced active-low pushbutton.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a debounced start pulse
// ST_LOAD  | capture A, B (inverted for subtract), SUB as carry-in
// ST_SHIFT | one adder bit per clock, WIDTH clocks
// ST_FIN   | DONE pulse; RESULT/OVERFLOW already updated on entry
module serial_addsub_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic             CLK_50,
    input  logic             RESET_N,
    input  logic             KEY_START_N,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVERFLOW,
    output logic             BUSY,
    output logic             DONE
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LOAD = DBW'(DB_CYCLES - 1);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_FIN
    } state_t;

    state_t state_q, state_d;

    logic s1_q, s1_d, s2_q, s2_d;
    logic db_q, db_d, db_prev_q, db_prev_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic start_pulse;

    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             sum_bit, carry_out;

    // Debounce timer counts down from DB_CYCLES-1; terminal count flips db.
    always_comb begin
        s1_d      = KEY_START_N;
        s2_d      = s1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        db_cnt_d  = db_cnt_q;
        if (s2_q == db_q) begin
            db_cnt_d = DB_LOAD;
        end else if (db_cnt_q == '0) begin
            db_d     = s2_q;
            db_cnt_d = DB_LOAD;
        end else begin
            db_cnt_d = db_cnt_q - 1'b1;
        end
    end

    assign start_pulse = db_prev_q & ~db_q;

    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_out = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                opa_d   = A;
                opb_d   = B ^ {WIDTH{SUB}};
                carry_d = SUB;
                cnt_d   = '0;
                a_msb_d = A[WIDTH-1];
                b_msb_d = B[WIDTH-1] ^ SUB;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                carry_d = carry_out;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                // Result registers load on entry to FIN so they are valid alongside DONE.
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_FIN;
                    result_d   = acc_d;
                    overflow_d = (a_msb_q == b_msb_q) & (sum_bit != a_msb_q);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            db_q       <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= DB_LOAD;
            state_q    <= ST_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            db_prev_q  <= db_prev_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign RESULT   = result_q;
    assign OVERFLOW = overflow_q;
    assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign DONE     = (state_q == ST_FIN);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl: vector table of operations plus
// hand-written debounce, busy-ignore and reset-abort sequences.
module tb_serial_addsub_ctrl;

    logic       CLK_50;
    logic       RESET_N;
    logic       KEY_START_N;
    logic       SUB;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] RESULT;
    logic       OVERFLOW;
    logic       BUSY;
    logic       DONE;

    serial_addsub_ctrl #(.WIDTH(4), .DB_CYCLES(4)) dut (
        .CLK_50     (CLK_50),
        .RESET_N    (RESET_N),
        .KEY_START_N(KEY_START_N),
        .SUB        (SUB),
        .A          (A),
        .B          (B),
        .RESULT     (RESULT),
        .OVERFLOW   (OVERFLOW),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK_50 = 1'b0;
    always #5 CLK_50 = ~CLK_50;

    int total  = 0;
    int passed = 0;
    int done_cnt  = 0;
    int busy_rise = 0;
    logic busy_prev = 1'b0;

    always @(negedge CLK_50) begin
        if (DONE) done_cnt++;
        if (BUSY && !busy_prev) busy_rise++;
        busy_prev = BUSY;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] exp_r;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sub,
                          input logic [3:0] er, input logic eo, input string tag);
        int n;
        int blen;
        int d0;
        @(posedge CLK_50); #1;
        A = a; B = b; SUB = sub; KEY_START_N = 1'b0;
        d0 = done_cnt;
        n = 0;
        @(negedge CLK_50);
        while (!BUSY && n < 30) begin
            @(negedge CLK_50);
            n++;
        end
        check({tag, "_busy_start"}, {31'b0, BUSY}, 32'd1);
        blen = 0;
        while (BUSY && blen < 20) begin
            blen++;
            @(negedge CLK_50);
        end
        check({tag, "_busy_len"}, blen, 32'd5);
        check({tag, "_done"}, {31'b0, DONE}, 32'd1);
        check({tag, "_result"}, {28'b0, RESULT}, {28'b0, er});
        check({tag, "_overflow"}, {31'b0, OVERFLOW}, {31'b0, eo});
        KEY_START_N = 1'b1;
        repeat (12) @(negedge CLK_50);
        check({tag, "_done_count"}, done_cnt - d0, 32'd1);
        check({tag, "_result_hold"}, {28'b0, RESULT}, {28'b0, er});
    endtask

    initial begin
        int d0;
        int b0;
        int n;

        vecs[0] = '{4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0};
        vecs[1] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1};
        vecs[2] = '{4'b0010, 4'b0101, 1'b1, 4'b1101, 1'b0};
        vecs[3] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1};
        vecs[4] = '{4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b1};
        vecs[5] = '{4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b0};
        vecs[6] = '{4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1};
        vecs[7] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0};
        vecs[8] = '{4'b0110, 4'b1100, 1'b1, 4'b1010, 1'b1};

        RESET_N = 1'b0; KEY_START_N = 1'b1; SUB = 1'b0; A = '0; B = '0;
        #1;
        check("reset_result", {28'b0, RESULT}, 32'd0);
        check("reset_overflow", {31'b0, OVERFLOW}, 32'd0);
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        repeat (3) @(posedge CLK_50);
        #1 RESET_N = 1'b1;
        repeat (4) @(negedge CLK_50);

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_r, vecs[i].exp_ov,
                   $sformatf("vec%0d", i));

        // Short glitch shorter than the hold time.
        b0 = busy_rise;
        @(posedge CLK_50); #1 KEY_START_N = 1'b0;
        repeat (3) @(posedge CLK_50);
        #1 KEY_START_N = 1'b1;
        repeat (12) @(negedge CLK_50);
        check("short_glitch_no_op", busy_rise - b0, 32'd0);

        // Bouncing press, then a solid hold.
        b0 = busy_rise; d0 = done_cnt;
        A = 4'b0001; B = 4'b0010; SUB = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK_50); #1 KEY_START_N = 1'b0;
            @(posedge CLK_50); #1 KEY_START_N = 1'b0;
            @(posedge CLK_50); #1 KEY_START_N = 1'b1;
        end
        @(posedge CLK_50); #1 KEY_START_N = 1'b0;
        repeat (10) @(posedge CLK_50);
        #1 KEY_START_N = 1'b1;
        repeat (15) @(negedge CLK_50);
        check("bounce_one_op", busy_rise - b0, 32'd1);
        check("bounce_one_done", done_cnt - d0, 32'd1);
        check("bounce_result", {28'b0, RESULT}, 32'h3);

        // Re-press and operand changes while busy.
        d0 = done_cnt;
        @(posedge CLK_50); #1;
        A = 4'b0011; B = 4'b0010; SUB = 1'b0; KEY_START_N = 1'b0;
        n = 0;
        @(negedge CLK_50);
        while (!BUSY && n < 30) begin
            @(negedge CLK_50);
            n++;
        end
        check("busy_ignore_start", {31'b0, BUSY}, 32'd1);
        @(negedge CLK_50);
        A = 4'b1111; B = 4'b1111; SUB = 1'b1; KEY_START_N = 1'b1;
        @(negedge CLK_50);
        KEY_START_N = 1'b0;
        n = 0;
        while (BUSY && n < 20) begin
            @(negedge CLK_50);
            n++;
        end
        check("busy_ignore_done", {31'b0, DONE}, 32'd1);
        check("busy_ignore_result", {28'b0, RESULT}, 32'h5);
        check("busy_ignore_overflow", {31'b0, OVERFLOW}, 32'd0);
        KEY_START_N = 1'b1;
        repeat (15) @(negedge CLK_50);
        check("busy_ignore_one_done", done_cnt - d0, 32'd1);

        // Reset during the second SHIFT cycle.
        run_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1, "pre_reset");
        @(posedge CLK_50); #1;
        A = 4'b0011; B = 4'b0010; SUB = 1'b0; KEY_START_N = 1'b0;
        n = 0;
        @(negedge CLK_50);
        while (!BUSY && n < 30) begin
            @(negedge CLK_50);
            n++;
        end
        check("abort_busy_start", {31'b0, BUSY}, 32'd1);
        @(negedge CLK_50);
        @(negedge CLK_50);
        d0 = done_cnt;
        RESET_N = 1'b0; KEY_START_N = 1'b1;
        #1;
        check("abort_result", {28'b0, RESULT}, 32'd0);
        check("abort_overflow", {31'b0, OVERFLOW}, 32'd0);
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK_50);
        RESET_N = 1'b1;
        repeat (8) @(negedge CLK_50);
        check("abort_no_done", done_cnt - d0, 32'd0);
        run_op(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial sequencer for the signed two's-complement add/subtract datapath behind the lab board's switch/7-segment display.
- Holds one shared full-adder cell and clocks operands through it LSB-first, so one adder bit is reused WIDTH times.
- Conditions a raw active-low pushbutton into a single start pulse.
- Presents a registered result and an overflow flag for the existing hex display logic.

Parameters:
- WIDTH, 4: operand/result width in bits; minimum 2.
- DB_CYCLES, 500000: debounce hold time in clocks (10 ms at 50 MHz); minimum 1; benches use 4.

Ports:
- CLK_50  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset; deassertion synchronous to CLK_50 upstream.
- KEY_START_N  input  1  raw pushbutton, active-low, asynchronous to CLK_50.
- SUB  input  1  0 = A+B, 1 = A-B; sampled in LOAD.
- A  input  WIDTH  signed operand A; sampled in LOAD.
- B  input  WIDTH  signed operand B; sampled in LOAD.
- RESULT  output  WIDTH  registered signed result.
- OVERFLOW  output  1  registered signed-overflow flag for RESULT.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when RESULT/OVERFLOW update.

Behaviour:

Reset (RESET_N=0, asynchronous):
- FSM=IDLE; RESULT=0, OVERFLOW=0, BUSY=0, DONE=0.
- Shift registers, carry and bit counter cleared.
- Synchronizer flops and debounced level set to 1 (released).
- Reset mid-operation aborts it; no DONE is produced for the aborted operation.

Input conditioning:
- KEY_START_N passes through a 2-flop synchronizer (s1, s2).
- Debounced level db changes only after s2 has differed from db for DB_CYCLES consecutive clocks. The counter clears whenever s2 equals db.
- start_pulse = db_prev & ~db: one cycle per press. Release produces nothing.
- A button held through reset release counts as one press, after DB_CYCLES.

FSM (IDLE, LOAD, SHIFT, FIN):
- IDLE:
  - start_pulse -> LOAD.
  - Otherwise stay.
- LOAD (1 cycle):
  - opA <= A; opB <= B ^ {WIDTH{SUB}}; carry <= SUB; cnt <= 0.
  - Latch a_msb = A[WIDTH-1] and b_msb = B[WIDTH-1]^SUB.
  - -> SHIFT.
- SHIFT (exactly WIDTH cycles):
  - s = opA[0]^opB[0]^carry; carry <= majority(opA[0], opB[0], carry).
  - opA and opB shift right; s shifts into the MSB of the accumulator.
  - cnt++; after cnt reaches WIDTH-1 -> FIN.
- FIN (1 cycle):
  - RESULT <= accumulator.
  - OVERFLOW <= (a_msb == b_msb) & (acc_msb != a_msb).
  - DONE=1; -> IDLE.

Timing:
- BUSY=1 in LOAD and SHIFT only, i.e. WIDTH+1 cycles.
- DONE=1 the cycle after BUSY falls; RESULT/OVERFLOW are valid from that cycle.
- Latency from start_pulse to DONE is WIDTH+2 cycles.
- RESULT/OVERFLOW hold until the next FIN or reset.

Boundary rules:
- start_pulse outside IDLE is dropped, not queued.
- A/B/SUB changes after LOAD have no effect on the operation in flight.
- Subtraction of the most-negative value (e.g. 0 - (-8)) reports OVERFLOW=1.
- Result wraps modulo 2^WIDTH.
- Carry-out is discarded; only signed overflow is reported.
- Back-to-back presses: a second operation may start from IDLE on the cycle after DONE.

Test Plan (WIDTH=4, DB_CYCLES=4):
- Add, no overflow: A=0011, B=0010, SUB=0, clean press -> BUSY high 5 cycles, then DONE pulse with RESULT=0101, OVERFLOW=0; exactly one DONE per press.
- Add, positive overflow: A=0111, B=0001, SUB=0 -> RESULT=1000, OVERFLOW=1.
- Subtract: A=0010, B=0101, SUB=1 -> RESULT=1101 (-3), OVERFLOW=0. Then A=1000, B=0001, SUB=1 -> RESULT=0111, OVERFLOW=1. Then A=0000, B=1000, SUB=1 -> RESULT=1000, OVERFLOW=1.
- Debounce: KEY_START_N low for 3 cycles then high -> no BUSY. Press bouncing 5 times within 3-cycle windows, then held low 10 cycles -> exactly one operation.
- Ignore while busy: second clean press issued while BUSY=1, and A changed during SHIFT -> single DONE; RESULT reflects the operands captured in LOAD.
- Reset mid-operation: RESET_N pulsed low during the 2nd SHIFT cycle -> RESULT=0, OVERFLOW=0, BUSY=0 immediately (asynchronous), no DONE. A fresh press afterward (0001+0001) -> RESULT=0010.
